// File: rtl/serial_sync_tx_if.sv
// serial_sync_tx_if: load/ready word handshake plus serial line outputs of the sync-pattern transmitter
interface serial_sync_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              str_out;
  logic              busy;
  logic              frame_done;
  modport master (output data_in, load, input ready, str_out, busy, frame_done);
  modport slave  (input data_in, load, output ready, str_out, busy, frame_done);
endinterface

// File: rtl/serial_sync_tx.sv
// serial_sync_tx: frames a word as sync pattern, data MSB first, optional even parity (PARITY_EN), one gap bit
module serial_sync_tx #(
  parameter int                  DATA_W   = 8,
  parameter int                  SYNC_LEN = 3,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 3'b110,
  parameter logic                IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  serial_sync_tx_if.slave  bus
);
  localparam int MAXL = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CW   = $clog2(MAXL) + 1;
  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    GAP
  } state_e;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [SYNC_LEN-1:0] pat_q, pat_d;
  logic                str_q, str_d;
  logic                fd_q, fd_d;
  logic                accept, sync_last, data_last;
`ifdef PARITY_EN
  logic                par_q, par_d;
`endif
  assign accept    = bus.load & bus.ready;
  assign sync_last = cnt_q == CW'(SYNC_LEN - 1);
  assign data_last = cnt_q == CW'(DATA_W - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pat_q   <= '0;
      str_q   <= IDLE_BIT;
      fd_q    <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pat_q   <= pat_d;
      str_q   <= str_d;
      fd_q    <= fd_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SYNC : IDLE;
      SYNC:    state_d = sync_last ? DATA : SYNC;
`ifdef PARITY_EN
      DATA:    state_d = data_last ? PARITY : DATA;
      PARITY:  state_d = GAP;
`else
      DATA:    state_d = data_last ? GAP : DATA;
`endif
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // registered line: each _d value is the bit that the next state puts on str_out
  always_comb begin
    cnt_d = (state_d == state_q && state_q != IDLE) ? cnt_q + 1'b1 : '0;
    sh_d  = accept ? bus.data_in : (state_d == DATA ? sh_q << 1 : sh_q);
    pat_d = accept ? SYNC_PAT << 1 : (state_d == SYNC ? pat_q << 1 : pat_q);
`ifdef PARITY_EN
    par_d = accept ? ^bus.data_in : par_q;
    fd_d  = state_d == PARITY;
    str_d = accept             ? SYNC_PAT[SYNC_LEN-1] :
            state_d == SYNC    ? pat_q[SYNC_LEN-1] :
            state_d == DATA    ? sh_q[DATA_W-1] :
            state_d == PARITY  ? par_q : IDLE_BIT;
`else
    fd_d  = state_d == DATA && cnt_d == CW'(DATA_W - 1);
    str_d = accept             ? SYNC_PAT[SYNC_LEN-1] :
            state_d == SYNC    ? pat_q[SYNC_LEN-1] :
            state_d == DATA    ? sh_q[DATA_W-1] : IDLE_BIT;
`endif
  end
  always_comb begin
    bus.ready      = state_q == IDLE;
    bus.busy       = state_q != IDLE;
    bus.str_out    = str_q;
    bus.frame_done = fd_q;
  end
endmodule
